// File: rtl/rr_arb_defs.sv
// Shared constants and state encoding for the 8-way round-robin arbiter.
// Feature macro RR_ARB_FIXED_PRIO_EN is consumed by rr_mux8_arbiter.
package rr_arb_defs;

    localparam int unsigned N_REQ = 8;
    localparam int unsigned SEL_W = 3;
    localparam int unsigned DAT_W = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FULL = 1'b1
    } state_t;

endpackage

// File: rtl/mux8x1.sv
// 8:1 selector for 2-bit payloads packed 2 bits per input.
// Input k occupies bits [2k+1:2k] of i_data.
module mux8x1 (
    input  logic [15:0] i_data,
    input  logic [2:0]  i_sel,
    output logic [1:0]  o_y
);

    assign o_y = i_data[{i_sel, 1'b0} +: 2];

endmodule

// File: rtl/rr_pick8.sv
// Rotate-priority encoder: first set request at or above the pointer,
// wrapping from 7 back to 0.
module rr_pick8
    import rr_arb_defs::*;
(
    input  logic [N_REQ-1:0] i_req,
    input  logic [SEL_W-1:0] i_ptr,
    output logic [SEL_W-1:0] o_idx,
    output logic             o_any
);

    logic             w_found;
    logic [SEL_W-1:0] w_k;

    always_comb begin
        o_idx   = '0;
        o_any   = |i_req;
        w_found = 1'b0;
        w_k     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            // 3-bit add wraps the search past requester 7
            w_k = i_ptr + SEL_W'(i);
            if (!w_found && i_req[w_k]) begin
                o_idx   = w_k;
                w_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_mux8_arbiter.sv
// Round-robin arbiter sharing one registered valid/ready output among 8.
// Define RR_ARB_FIXED_PRIO_EN for fixed priority (requester 0 highest).
module rr_mux8_arbiter #(
    parameter int unsigned PTR_INIT = 0,
    parameter int unsigned DAT_W    = 2
) (
    input  logic               iClk,
    input  logic               iRst,
    input  logic [7:0]         iReq,
    input  logic [8*DAT_W-1:0] iData,
    output logic [7:0]         oGnt,
    output logic               oValid,
    output logic [DAT_W-1:0]   oX,
    output logic [2:0]         oSel,
    input  logic               iReady
);

    import rr_arb_defs::*;

`ifdef RR_ARB_FIXED_PRIO_EN
    localparam logic [SEL_W-1:0] PTR_RST = '0;
`else
    localparam logic [SEL_W-1:0] PTR_RST = SEL_W'(PTR_INIT);
`endif

    state_t           r_state;
    state_t           w_state_nxt;
    logic [SEL_W-1:0] r_ptr;
    logic [SEL_W-1:0] w_ptr_nxt;
    logic [SEL_W-1:0] r_sel;
    logic [SEL_W-1:0] w_sel_nxt;
    logic [SEL_W-1:0] w_idx;
    logic [DAT_W-1:0] r_x;
    logic [DAT_W-1:0] w_x_nxt;
    logic [DAT_W-1:0] w_mux;
    logic             w_any;
    logic             w_arb_en;
    logic             w_fire;

    rr_pick8 u_pick (
        .i_req (iReq),
        .i_ptr (r_ptr),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    mux8x1 u_mux (
        .i_data (iData),
        .i_sel  (w_idx),
        .o_y    (w_mux)
    );

    assign w_arb_en = (r_state == ST_IDLE) | (iReady & oValid);
    // Reset suppresses the grant so no requester believes it was consumed
    assign w_fire   = w_arb_en & w_any & ~iRst;
    assign oGnt     = w_fire ? (8'b1 << w_idx) : 8'b0;

    assign oValid = (r_state == ST_FULL);
    assign oX     = r_x;
    assign oSel   = r_sel;

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_sel_nxt   = r_sel;
        w_x_nxt     = r_x;
        if (w_arb_en) begin
            if (w_any) begin
                w_state_nxt = ST_FULL;
                w_sel_nxt   = w_idx;
                w_x_nxt     = w_mux;
`ifndef RR_ARB_FIXED_PRIO_EN
                w_ptr_nxt   = SEL_W'(w_idx + 3'd1);
`endif
            end else begin
                w_state_nxt = ST_IDLE;
            end
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state <= ST_IDLE;
            r_ptr   <= PTR_RST;
            r_sel   <= '0;
            r_x     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_sel   <= w_sel_nxt;
            r_x     <= w_x_nxt;
        end
    end

endmodule

// File: tb/tb_rr_mux8_arbiter.sv
// Scoreboard bench for rr_mux8_arbiter with a behavioural arbitration model.
// Honours RR_ARB_FIXED_PRIO_EN when the build defines it.
module tb_rr_mux8_arbiter;

    localparam int PTR_INIT = 0;

    logic        iClk;
    logic        iRst;
    logic [7:0]  iReq;
    logic [15:0] iData;
    logic [7:0]  oGnt;
    logic        oValid;
    logic [1:0]  oX;
    logic [2:0]  oSel;
    logic        iReady;

    rr_mux8_arbiter #(
        .PTR_INIT (PTR_INIT),
        .DAT_W    (2)
    ) dut (
        .iClk   (iClk),
        .iRst   (iRst),
        .iReq   (iReq),
        .iData  (iData),
        .oGnt   (oGnt),
        .oValid (oValid),
        .oX     (oX),
        .oSel   (oSel),
        .iReady (iReady)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: output register occupancy and round-robin pointer
    int m_valid;
    int m_ptr;
    int last_win;

    typedef struct {
        int sel;
        int x;
    } exp_t;

    exp_t sb[$];

    function automatic void chk(string nm, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endfunction

    task automatic step(input logic rst, input logic [7:0] req,
                        input logic [15:0] dat, input logic rdy);
        int en;
        int win;
        int k;
        int egnt;
        exp_t e;
        @(negedge iClk);
        iRst   = rst;
        iReq   = req;
        iData  = dat;
        iReady = rdy;
        #1;
        en  = (m_valid == 0) || (rdy == 1'b1);
        win = -1;
        if (!rst && en) begin
            for (int i = 0; i < 8; i++) begin
`ifdef RR_ARB_FIXED_PRIO_EN
                k = i;
`else
                k = (m_ptr + i) % 8;
`endif
                if (win < 0 && req[k]) win = k;
            end
        end
        egnt = (win >= 0) ? (1 << win) : 0;
        chk("gnt", int'(oGnt), egnt);
        chk("valid", int'(oValid), m_valid);
        last_win = win;
        if (rst) begin
            m_valid = 0;
            m_ptr   = PTR_INIT;
            sb.delete();
        end else if (en) begin
            if (win >= 0) begin
                e.sel   = win;
                e.x     = int'(dat[2*win +: 2]);
                sb.push_back(e);
                m_valid = 1;
                m_ptr   = (win + 1) % 8;
            end else begin
                m_valid = 0;
            end
        end
    endtask

    // Monitor: every accepted output beat must match the oldest grant
    initial begin
        exp_t e;
        forever begin
            @(negedge iClk);
            #2;
            if (iRst === 1'b0 && oValid === 1'b1 && iReady === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("out_sel", int'(oSel), e.sel);
                    chk("out_x", int'(oX), e.x);
                end
            end
        end
    end

    logic [7:0] pend;
    logic [1:0] pdat [8];
    int         wcnt [8];
    logic [15:0] rdat;

    initial begin
        iRst   = 1'b1;
        iReq   = 8'hFF;
        iData  = 16'hE4E4;
        iReady = 1'b1;
        m_valid = 0;
        m_ptr   = PTR_INIT;
        last_win = -1;

        step(1'b1, 8'hFF, 16'hE4E4, 1'b1);
        step(1'b1, 8'hFF, 16'hE4E4, 1'b1);
        @(posedge iClk);
        #1;
        chk("rst_valid", int'(oValid), 0);
        chk("rst_x", int'(oX), 0);
        chk("rst_sel", int'(oSel), 0);

`ifndef RR_ARB_FIXED_PRIO_EN
        for (int i = 0; i < 9; i++) begin
            step(1'b0, 8'hFF, 16'hE4E4, 1'b1);
            chk("rot_win", last_win, i % 8);
        end
        step(1'b0, 8'h00, 16'h0000, 1'b1);

        step(1'b0, 8'h20, 16'h0C00, 1'b0);
        chk("bp_first", last_win, 5);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 8'h20, 16'h0C00, 1'b0);
            chk("bp_hold_gnt", last_win, -1);
        end
        @(posedge iClk);
        #1;
        chk("bp_valid", int'(oValid), 1);
        chk("bp_x", int'(oX), 3);
        chk("bp_sel", int'(oSel), 5);
        step(1'b0, 8'h00, 16'h0000, 1'b1);
        step(1'b0, 8'h00, 16'h0000, 1'b1);

        step(1'b0, 8'h41, 16'h2003, 1'b1);
        chk("fair_a", last_win, 6);
        step(1'b0, 8'h41, 16'h1001, 1'b1);
        chk("fair_b", last_win, 0);
        step(1'b0, 8'h41, 16'h3002, 1'b1);
        chk("fair_c", last_win, 6);
        step(1'b0, 8'h00, 16'h0000, 1'b1);
`else
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 8'h81, 16'h8002, 1'b1);
            chk("fixed_win", last_win, 0);
        end
        step(1'b0, 8'h00, 16'h0000, 1'b1);
`endif

        step(1'b0, 8'h08, 16'h00C0, 1'b1);
        step(1'b0, 8'h00, 16'h0000, 1'b0);
        step(1'b1, 8'h00, 16'h0000, 1'b0);
        @(posedge iClk);
        #1;
        chk("mrst_valid", int'(oValid), 0);
        step(1'b0, 8'hFF, 16'hE4E4, 1'b1);
        chk("mrst_ptr", last_win, 0);
        step(1'b0, 8'h00, 16'h0000, 1'b1);

        pend = '0;
        for (int k = 0; k < 8; k++) begin
            pdat[k] = '0;
            wcnt[k] = 0;
        end
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 8; k++) begin
                if (!pend[k] && $urandom_range(0, 2) == 0) begin
                    pend[k] = 1'b1;
                    pdat[k] = 2'($urandom_range(0, 3));
                    wcnt[k] = 0;
                end
            end
            rdat = '0;
            for (int k = 0; k < 8; k++) rdat[2*k +: 2] = pdat[k];
            if ($urandom_range(0, 199) == 0) begin
                step(1'b1, pend, rdat, 1'b1);
                for (int k = 0; k < 8; k++) wcnt[k] = 0;
            end else begin
                step(1'b0, pend, rdat, 1'($urandom_range(0, 3) != 0));
            end
            if (last_win >= 0) begin
`ifndef RR_ARB_FIXED_PRIO_EN
                chk("starve", int'(wcnt[last_win] <= 7), 1);
`endif
                for (int k = 0; k < 8; k++) begin
                    if (pend[k] && k != last_win) wcnt[k]++;
                end
                pend[last_win] = 1'b0;
                wcnt[last_win] = 0;
            end
        end

        step(1'b0, 8'h00, 16'h0000, 1'b1);
        step(1'b0, 8'h00, 16'h0000, 1'b1);
        step(1'b0, 8'h00, 16'h0000, 1'b1);
        chk("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_mux8_arbiter.md
Name: rr_mux8_arbiter

Overview:
- Round-robin arbiter and sequencer for the 8:1 2-bit selection datapath.
- Shares one registered output channel between 8 requesters, each presenting a 2-bit payload.
- Drives the mux select and registers the chosen payload into a valid/ready output stage.
- Sits between the normalization front-end requesters and the downstream consumer of 2-bit selector codes.

Parameters:
- PTR_INIT, 0: round-robin pointer value after reset, range 0..7.
- DAT_W, 2: payload width. Fixed at 2 to match the mux datapath; any other value is illegal.

Ports:
- iClk  in  1  clock; all state updates on rising edge.
- iRst  in  1  reset, synchronous, active-high.
- iReq  in  8  request vector; bit k set means requester k holds a valid payload.
- iData  in  16  packed payloads; requester k at bits [2k+1:2k].
- oGnt  out  8  one-hot grant, combinational. oGnt[k]&iReq[k] means payload k is consumed this cycle.
- oValid  out  1  output payload valid.
- oX  out  2  registered selected payload.
- oSel  out  3  index of the requester whose payload is in oX.
- iReady  in  1  downstream accepts oX when oValid&iReady.

Behaviour:
- Reset (iRst=1 at an edge): oValid=0, oX=0, oSel=0, state=IDLE, pointer=PTR_INIT. While iRst=1, oGnt=0 (forced).
- Reset mid-operation: any held payload is dropped without handshake, and no grant is issued in that cycle.
- States:
  - IDLE: output register empty.
  - FULL: oValid=1, holding a payload.
- Arbitration enable: `arb_en = (state==IDLE) | (iReady & oValid)`.
- Winner selection: the first set bit of iReq searched from the pointer upward, wrapping 7→0.
  - oGnt = one-hot(winner) when arb_en & |iReq, else 0.
- On an edge with arb_en & |iReq:
  - oX ← iData[winner].
  - oSel ← winner.
  - oValid ← 1, state ← FULL.
  - pointer ← (winner+1) mod 8, so winner 7 wraps the pointer to 0.
- On an edge with arb_en & ~|iReq: oValid ← 0, state ← IDLE, pointer unchanged.
- FULL & ~iReady: oX, oSel, oValid held stable; oGnt=0; pointer unchanged.
- Simultaneous drain and refill (FULL & iReady & |iReq): a new payload is loaded in the same cycle, giving throughput of one payload per cycle.
- Latency: request to oValid is 1 cycle. Grant is issued in the capture cycle.
- Single requester held high continuously: it is granted every cycle that arb_en is true.
- A requester must keep iReq and its iData stable until granted. After a grant it may present its next payload immediately.
- Starvation bound: a continuously requesting source waits at most 7 grants.
- The select into the mux equals the combinational winner index. oSel is the registered copy of that index.

Optional Feature:
- Macro RR_ARB_FIXED_PRIO_EN.
  - Defined: the pointer is ignored and held at 0. The winner is always the lowest set index of iReq (fixed priority; requester 0 highest).
  - Undefined: round-robin exactly as described above.
- All other behaviour is identical in both builds.

Decomposition:
- Shared include/package rr_arb_defs:
  - N_REQ=8, SEL_W=3, DAT_W=2.
  - State encodings ST_IDLE=1'b0, ST_FULL=1'b1.
- Natural sub-module rr_pick8:
  - Combinational rotate-priority encoder.
  - Inputs: 8-bit request, 3-bit pointer.
  - Outputs: 3-bit index and an any-request flag.
- Payload selection reuses the team's existing 8:1 2-bit mux (mux8x1), with its select driven by the rr_pick8 index.

Test Plan:
- Reset values: hold iRst=1 for 2 cycles with iReq=8'hFF → oGnt=0, oValid=0, oX=0, oSel=0. Then release with iData=16'hE4E4 and iReady=1 → first grant goes to requester 0; oSel=0, oX=2'b00.
- Round-robin rotation: iReq=8'hFF, iReady=1, iData[2k+1:2k]=k mod 4 → oSel sequence 0,1,...,7,0 on consecutive cycles. Wrap from 7 to 0 is verified; oValid stays 1 throughout.
- Backpressure: single iReq=8'h20, iData[11:10]=2'b11, iReady=0 for 5 cycles → oValid=1, oX=3, oSel=5 held stable; oGnt=0 after the first cycle. Raising iReady consumes it; oValid drops next cycle once iReq=0.
- Fairness with gaps: pointer at 6, iReq=8'h41 → grant 6, then 0. Then with iReq=8'h41 again and pointer at 1 → grant 6.
- Reset mid-operation: with oValid=1 and iReady=0, assert iRst for 1 cycle → oValid=0 and pointer=PTR_INIT. The dropped payload is not presented again.
- RR_ARB_FIXED_PRIO_EN defined: iReq=8'h81 held, iReady=1 → oSel=0 every cycle; requester 7 is never granted while bit 0 stays set.
